// File: rtl/fpu_pkg.sv
// fpu_pkg
// Shared definitions for the floating-point issue path: opcode encoding,
// number of FPU strobe lines and the issue sequencer state type.
package fpu_pkg;

  localparam int FPU_NUNITS = 10;

  // Opcode value doubles as the bit index of the unit's issue strobe.
  typedef enum logic [3:0] {
    FOP_NOP   = 4'd0,
    FOP_FADD  = 4'd1,
    FOP_FSUB  = 4'd2,
    FOP_FMUL  = 4'd3,
    FOP_FDIV  = 4'd4,
    FOP_FSQRT = 4'd5,
    FOP_FABS  = 4'd6,
    FOP_FCMP  = 4'd7,
    FOP_FFTOI = 4'd8,
    FOP_FITOF = 4'd9
  } fpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } fpu_issue_state_t;

  // True for the opcodes that map onto a real unit.
  function automatic logic op_is_unit(input logic [3:0] op);
    return (op != FOP_NOP) && (op <= FOP_FITOF);
  endfunction

endpackage

// File: rtl/fpu_issue.sv
// fpu_issue
// Issue-and-writeback sequencer in front of the FPU result mux.
// Accepts one decoded FP op at a time, raises the matching one-hot issue
// strobe, holds operands, waits for the result (with a watchdog) and then
// presents the result to the FP register-file write port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   dec_valid/dec_ready      decoded-op handshake
//   dec_op, dec_rd           opcode (0 nop, 1..9 units, 10..15 illegal), dest reg
//   dec_data_a/b             forwarded operands
//   fpu_in_valid             one-hot registered issue strobe (bit 0 unused)
//   fpu_in_a/b               operands held from issue through writeback
//   fpu_out, fpu_out_valid   result from the FPU
//   wb_valid/wb_ready        writeback handshake
//   wb_rd, wb_data           writeback register and data
//   busy                     sequencer not idle
//   err                      one-cycle pulse: illegal op, timeout or spurious result
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [3:0]            dec_op,
  input  logic [4:0]            dec_rd,
  input  logic [31:0]           dec_data_a,
  input  logic [31:0]           dec_data_b,
  output logic [FPU_NUNITS-1:0] fpu_in_valid,
  output logic [31:0]           fpu_in_a,
  output logic [31:0]           fpu_in_b,
  input  logic [31:0]           fpu_out,
  input  logic                  fpu_out_valid,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  busy,
  output logic                  err
);

  localparam logic [FPU_NUNITS-1:0] STROBE_ONE = FPU_NUNITS'(1);
  localparam logic [7:0]            TIMEOUT_8  = 8'(TIMEOUT);

  fpu_issue_state_t state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             issue_go;
  logic             capture;
  logic             expire;
  logic             err_d;
  logic [7:0]       cnt_inc;

  assign cnt_inc   = cnt_q + 8'd1;
  assign dec_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign wb_valid  = (state_q == ST_WB);

  // State register. Reset can land in any state and simply abandons the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode. The watchdog compares the count this
  // WAIT cycle would reach, so TIMEOUT is the number of WAIT cycles spent
  // before forced completion. A result arriving in the expiry cycle wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issue_go = 1'b0;
    capture  = 1'b0;
    expire   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fpu_out_valid) err_d = 1'b1;
        if (dec_valid) begin
          if (op_is_unit(dec_op)) begin
            issue_go = 1'b1;
            state_d  = ST_ISSUE;
          end else if (dec_op != FOP_NOP) begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = 8'd0;
        if (fpu_out_valid) begin
          capture = 1'b1;
          state_d = ST_WB;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (fpu_out_valid) begin
          capture = 1'b1;
          state_d = ST_WB;
        end else if (cnt_inc == TIMEOUT_8) begin
          expire  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (fpu_out_valid) err_d = 1'b1;
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: the issue strobe and err are single-cycle pulses,
  // operands and destination are latched on accept, and the writeback data
  // is loaded either from the FPU or forced to zero by the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_in_valid <= '0;
      fpu_in_a     <= '0;
      fpu_in_b     <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      cnt_q        <= '0;
      err          <= 1'b0;
    end else begin
      fpu_in_valid <= issue_go ? (STROBE_ONE << dec_op) : '0;
      err          <= err_d;
      cnt_q        <= cnt_d;
      if (issue_go) begin
        fpu_in_a <= dec_data_a;
        fpu_in_b <= dec_data_b;
        wb_rd    <= dec_rd;
      end
      if (capture) begin
        wb_data <= fpu_out;
      end else if (expire) begin
        wb_data <= '0;
      end
    end
  end

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Issue-and-writeback sequencer directly upstream of the FPU result mux. Accepts one decoded floating-point operation at a time, converts its opcode into the one-hot `fpu_in_valid` strobe, holds the operands on `fpu_in_a`/`fpu_in_b`, and waits for `fpu_out_valid`. It then presents the result with its destination register to the FP register-file write port. A watchdog recovers from a unit that never answers.

## Interface
- `TIMEOUT`, default 255: maximum WAIT cycles before forced completion; range 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `dec_valid`  in  1  decoded FP op present.
- `dec_ready`  out  1  block accepts an op this cycle.
- `dec_op`  in  4  0 = nop; 1..9 = fadd, fsub, fmul, fdiv, fsqrt, fabs, fcmp, fftoi, fitof (equals the `fpu_in_valid` bit index); 10..15 are illegal.
- `dec_rd`  in  5  destination register.
- `dec_data_a`, `dec_data_b`  in  32 each  operands, already forwarded.
- `fpu_in_valid`  out  10  one-hot issue strobe; bit 0 is never driven.
- `fpu_in_a`, `fpu_in_b`  out  32 each  held operands.
- `fpu_out`  in  32  result.
- `fpu_out_valid`  in  1  result valid.
- `wb_valid`  out  1  writeback request.
- `wb_ready`  in  1  register file accepts the write.
- `wb_rd`  out  5  writeback register.
- `wb_data`  out  32  writeback data.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  one-cycle pulse on an illegal op, a timeout, or a spurious result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB.
- `dec_ready` = (state == IDLE).
- IDLE, on accept (`dec_valid` && `dec_ready`):
  - `dec_op` 1..9: latch op, rd, a and b; go to ISSUE.
  - `dec_op` 0: discard; stay in IDLE; no strobe, no writeback.
  - `dec_op` 10..15: discard; pulse `err` next cycle; stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive `fpu_in_valid[op]` = 1; clear the watchdog counter.
  - If `fpu_out_valid` is also high this cycle, capture `fpu_out` and go to WB. Otherwise go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - `fpu_out_valid` high: capture `fpu_out`; go to WB.
  - Else, if the counter equals `TIMEOUT`: `wb_data` = 0, pulse `err`, go to WB.
  - A result in the same cycle as expiry wins; no `err`.
- WB:
  - Hold `wb_valid`, `wb_rd` and `wb_data` stable until `wb_ready`, then return to IDLE.
  - No new op is accepted in the `wb_ready` cycle.
- `fpu_out_valid` while in IDLE or WB: ignored; pulse `err`.
- `fpu_in_a` and `fpu_in_b` stay at their latched values from ISSUE through WB. They change only on the next accept.

## Timing
- Reset (async, any state) sets:
  - state = IDLE; `fpu_in_valid` = 0; `fpu_in_a` = `fpu_in_b` = 0;
  - `wb_valid` = 0; `wb_rd` = 0; `wb_data` = 0;
  - `busy` = 0; `err` = 0; counter = 0; `dec_ready` = 1.
- Reset mid-WAIT drops the op silently; a late `fpu_out_valid` then raises `err`.
- Latency, with accept at cycle t:
  - Strobe at t+1.
  - Result at cycle r ≥ t+1 gives `wb_valid` at r+1.
  - Next accept possible at the cycle after the `wb_ready` handshake.
- Minimum occupancy is 3 cycles per op (ISSUE, WB, IDLE) when the result arrives in ISSUE and `wb_ready` = 1.
- `err` and `fpu_in_valid` are registered single-cycle pulses.

## Structure
- Shared package `fpu_pkg` holds:
  - `fpu_op_t` enum: FOP_NOP = 0 … FOP_FITOF = 9.
  - `FPU_NUNITS` = 10.
  - `fpu_issue_state_t` enum.
- No sub-module. The one-hot decode is a shift of 1 by `op`.

## Test plan
- Accept fadd (op 1), a = 0x3F800000, b = 0x40000000; result 0x40400000 arrives 3 cycles after the strobe -> `fpu_in_valid` = 0x002 for one cycle; `wb_valid` with `wb_rd` = `dec_rd` and `wb_data` = 0x40400000.
- fabs (op 6) with `fpu_out_valid` in the ISSUE cycle -> go straight to WB; `wb_valid` at t+2.
- `dec_op` = 12 -> no strobe, `err` pulse, `busy` stays 0; `dec_op` = 0 -> no strobe, no `err`, no writeback.
- `TIMEOUT` = 4, fdiv never answers -> after 4 WAIT cycles `err` pulses, `wb_data` = 0, and the FSM returns to IDLE after `wb_ready`.
- `wb_ready` held low for 5 cycles -> `wb_*` stable, `dec_ready` = 0 throughout; spurious `fpu_out_valid` during WB -> `err` pulse, `wb_data` unchanged.
- Assert `rst` during WAIT -> all outputs 0 immediately; a later `fpu_out_valid` -> `err` pulse and no writeback.
